irb_dw_engine: RTL and testbench
================================

# irb_dw_engine

Depthwise 3x3 convolution engine of the inverted-residual block datapath. It sits directly downstream of the expansion stage. It reads one tile of the expanded intermediate feature map from the FMINT RAM (9x9 pixels per channel, up to `NPAR` channels) and the matching depthwise kernels from the KDW RAM. It computes 7x7 output pixels per channel with one sequential multiply-accumulate unit and writes them, rounded and saturated, to the tile output buffer that feeds the projection stage.

## Interface
- `NKX`, default 3: kernel width.
- `NKY`, default 3: kernel height.
- `TOX`, default 7: output tile width; `TIX = TOX+NKX-1` (derived).
- `TOY`, default 7: output tile height; `TIY = TOY+NKY-1` (derived).
- `NPAR`, default 32: maximum channels per tile.
- `PX_W`, default 16: signed pixel width.
- `WG_W`, default 16: signed weight width.
- `FRAC`, default 8: fractional bits shared by pixels and weights; output is Q(PX_W-FRAC).FRAC.
- `ACC_W`, default 40: accumulator width.
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `start` in 1: begin a tile; sampled only in IDLE.
- `n_ch` in clog2(NPAR+1): channels to process, 0..NPAR; latched on start.
- `busy` out 1: high from the cycle after start is accepted until done.
- `done` out 1: one-cycle completion pulse.
- `fmint_rd_en` out 1: FMINT read strobe.
- `fmint_addr` out clog2(TIX*TIY*NPAR): `ch*TIX*TIY + (oy+ky)*TIX + (ox+kx)`.
- `fmint_data` in PX_W: valid the cycle after `fmint_rd_en`.
- `kdw_rd_en` out 1: KDW read strobe, same cycle as `fmint_rd_en`.
- `kdw_addr` out clog2(NKX*NKY*NPAR): `ch*NKX*NKY + ky*NKX + kx`.
- `kdw_data` in WG_W: valid the cycle after `kdw_rd_en`.
- `fmo_wr_en` out 1: output write strobe.
- `fmo_addr` out clog2(TOX*TOY*NPAR): `ch*TOX*TOY + oy*TOX + ox`.
- `fmo_data` out PX_W: result pixel.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 with `n_ch`>0 latches `n_ch`, clears the counters and moves to RUN.
  - `start`=1 with `n_ch`=0 moves to DONE directly.
- RUN:
  - Issues one read pair per cycle.
  - Loop nest, outermost to innermost: ch (0..n_ch-1), oy, ox, ky, kx (kx fastest).
  - Moves to DRAIN after the read for the last tap (ch=n_ch-1, oy=TOY-1, ox=TOX-1, ky=NKY-1, kx=NKX-1).
- DRAIN: waits until the pipeline is empty, then moves to DONE.
- DONE: pulses `done`, returns to IDLE.
- `start` is ignored outside IDLE.
- Pipeline, with tap flags (first/last, output address) travelling alongside the data:
  - P0 issues the reads.
  - P1 registers the full-precision signed product `fmint_data*kdw_data` (PX_W+WG_W bits).
  - P2 accumulates. The first tap of a pixel loads the product; later taps add it.
- Accumulation has no bubbles between consecutive output pixels.
- Output conversion on the last tap of a pixel:
  - Add `1<<(FRAC-1)`.
  - Arithmetic shift right by FRAC.
  - Saturate to the signed PX_W range.
- Sign-extend every product to ACC_W bits before accumulating; the accumulator must never wrap for any PX_W/WG_W input.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- `rst` asserted mid-operation:
  - Aborts the tile next edge.
  - Drops in-flight products; no further `fmo_wr_en`.
  - No `done` pulse.
- Latency:
  - Start accepted at edge 0; first read issued in cycle 1.
  - Pixel k writes in cycle `9*(k+1)+3`, i.e. 3 cycles after its last tap read.
- Tile length: last write at cycle `n_ch*TOX*TOY*NKX*NKY + 3`; `done` the following cycle.
  - n_ch=1: writes at cycles 12, 21, …, 444; `done` at cycle 445.
- `n_ch=0`: `done` at cycle 1 with no reads or writes.
- `busy` is high in RUN, DRAIN and DONE.

## Configuration
- `IRB_DW_RELU6_EN` defined: after saturation, clamp the result to `[0, 6<<FRAC]` (ReLU6). The MobileNetV2 depthwise activation is fused here.
- Not defined: the output is the saturated value only, negatives are passed through, and no upper clamp other than saturation is applied.

## Test plan
- Ones test:
  - Stimulus: n_ch=1, all pixels 256, all weights 256.
  - Response: 49 writes of 2304 (0x0900), addresses 0..48; with `IRB_DW_RELU6_EN`, 1536 (0x0600).
- Identity kernel with ramp input:
  - Stimulus: center weight 256, other weights 0, pixel(y,x)=y*9+x as an integer times 256; n_ch=2, channel 1 offset by +1000.
  - Response: fmo(ch,oy,ox) = ((oy+1)*9+ox+1+1000*ch)*256, saturated to 0x7FFF where exceeded.
- Saturation and sign:
  - Stimulus A: pixels 0x7FFF, weights 0x7FFF. Response: all outputs 0x7FFF.
  - Stimulus B: pixels 256, weights -256. Response: 0xF700 without the macro, 0x0000 with it.
- Rounding:
  - Stimulus: one tap 128×1 (product 128), all other taps 0.
  - Response: output 1 (0.5 LSB rounds up). Product -129 gives -1.
- Cycle and control:
  - Stimulus: n_ch=32, with `start` pulsed again mid-run.
  - Response: the second start is ignored; exactly 1568 writes; `done` at cycle 14116. n_ch=0 gives `done` at cycle 1.
- Reset mid-run:
  - Stimulus: `rst` at cycle 200, then a new start.
  - Response: outputs 0 and no `done` after reset; the new tile completes normally from address 0.

Source files
------------

// File: rtl/irb_dw_engine.sv
// irb_dw_engine
// Depthwise 3x3 convolution engine of the inverted-residual block.
// Reads a 9x9 tile per channel from FMINT and the matching 3x3 kernel
// from KDW, runs a single sequential multiply-accumulate unit over
// ch / oy / ox / ky / kx (kx fastest), and writes each 7x7 output pixel,
// rounded and saturated, to the tile output buffer.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, n_ch       begin a tile of n_ch channels (sampled only in IDLE)
//   busy, done        status: busy in RUN/DRAIN/DONE, done is a 1-cycle pulse
//   fmint_rd_en/addr  feature-map read port, data returns the next cycle
//   fmint_data
//   kdw_rd_en/addr    kernel read port, issued alongside the FMINT read
//   kdw_data
//   fmo_wr_en/addr    result write port
//   fmo_data
//
// Optional build macro
//   IRB_DW_RELU6_EN   when defined, clamps each result to [0, 6.0] (ReLU6)
//                     after saturation.

module irb_dw_engine #(
   parameter int NKX   = 3,
   parameter int NKY   = 3,
   parameter int TOX   = 7,
   parameter int TOY   = 7,
   parameter int NPAR  = 32,
   parameter int PX_W  = 16,
   parameter int WG_W  = 16,
   parameter int FRAC  = 8,
   parameter int ACC_W = 40
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             start,
   input  logic [$clog2(NPAR+1)-1:0]                        n_ch,
   output logic                                             busy,
   output logic                                             done,
   output logic                                             fmint_rd_en,
   output logic [$clog2((TOX+NKX-1)*(TOY+NKY-1)*NPAR)-1:0]  fmint_addr,
   input  logic [PX_W-1:0]                                  fmint_data,
   output logic                                             kdw_rd_en,
   output logic [$clog2(NKX*NKY*NPAR)-1:0]                  kdw_addr,
   input  logic [WG_W-1:0]                                  kdw_data,
   output logic                                             fmo_wr_en,
   output logic [$clog2(TOX*TOY*NPAR)-1:0]                  fmo_addr,
   output logic [PX_W-1:0]                                  fmo_data
);

   localparam int TIX    = TOX + NKX - 1;
   localparam int TIY    = TOY + NKY - 1;
   localparam int CH_W   = $clog2(NPAR + 1);
   localparam int FA_W   = $clog2(TIX * TIY * NPAR);
   localparam int KA_W   = $clog2(NKX * NKY * NPAR);
   localparam int OA_W   = $clog2(TOX * TOY * NPAR);
   localparam int KX_W   = (NKX > 1) ? $clog2(NKX) : 1;
   localparam int KY_W   = (NKY > 1) ? $clog2(NKY) : 1;
   localparam int OX_W   = (TOX > 1) ? $clog2(TOX) : 1;
   localparam int OY_W   = (TOY > 1) ? $clog2(TOY) : 1;
   localparam int PROD_W = PX_W + WG_W;

   localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (FRAC - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-PX_W+1){1'b0}}, {(PX_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-PX_W+1){1'b1}}, {(PX_W-1){1'b0}}};
`ifdef IRB_DW_RELU6_EN
   localparam logic signed [PX_W-1:0]  RELU_MAX = PX_W'(6 << FRAC);
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [CH_W-1:0] nch_q, nch_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic [OY_W-1:0] oy_q, oy_d;
   logic [OX_W-1:0] ox_q, ox_d;
   logic [KY_W-1:0] ky_q, ky_d;
   logic [KX_W-1:0] kx_q, kx_d;

   logic            running;
   logic            lastTap;
   logic            firstOfPix;
   logic            lastOfPix;
   logic [OA_W-1:0] issueOaddr;

   // Stage A: tags for the read issued last cycle, aligned with returning data
   logic            rdV_q;
   logic            rdFirst_q;
   logic            rdLast_q;
   logic [OA_W-1:0] rdOaddr_q;

   // Stage B: registered product and its tags
   logic                      prodV_q;
   logic                      prodFirst_q;
   logic                      prodLast_q;
   logic [OA_W-1:0]           prodOaddr_q;
   logic signed [PROD_W-1:0]  prod_q;

   logic signed [ACC_W-1:0]   acc_q;
   logic                      fmoWr_q;
   logic [OA_W-1:0]           fmoAddr_q;
   logic [PX_W-1:0]           fmoData_q;

   logic signed [ACC_W-1:0]   prodExt;
   logic signed [ACC_W-1:0]   accSum;
   logic signed [ACC_W-1:0]   rounded;
   logic signed [ACC_W-1:0]   shifted;
   logic signed [PX_W-1:0]    satPix;
   logic signed [PX_W-1:0]    outPix;

   // Tap decode and read address generation; addresses are held at zero
   // whenever no read is being issued.
   always_comb begin
      running     = (state_q == RUN);
      firstOfPix  = (ky_q == '0) && (kx_q == '0);
      lastOfPix   = (ky_q == KY_W'(NKY - 1)) && (kx_q == KX_W'(NKX - 1));
      lastTap     = running && lastOfPix
                    && (ch_q == nch_q - CH_W'(1))
                    && (oy_q == OY_W'(TOY - 1))
                    && (ox_q == OX_W'(TOX - 1));
      issueOaddr  = OA_W'(ch_q) * OA_W'(TOX * TOY) + OA_W'(oy_q) * OA_W'(TOX) + OA_W'(ox_q);
      fmint_rd_en = running;
      kdw_rd_en   = running;
      fmint_addr  = '0;
      kdw_addr    = '0;
      if (running) begin
         fmint_addr = FA_W'(ch_q) * FA_W'(TIX * TIY)
                    + (FA_W'(oy_q) + FA_W'(ky_q)) * FA_W'(TIX)
                    + FA_W'(ox_q) + FA_W'(kx_q);
         kdw_addr   = KA_W'(ch_q) * KA_W'(NKX * NKY) + KA_W'(ky_q) * KA_W'(NKX) + KA_W'(kx_q);
      end
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

   // Next-state logic and loop counters. DRAIN waits only for the two
   // pipeline stages ahead of the accumulator; the final write leaves the
   // output register during the cycle that DRAIN hands over to DONE.
   always_comb begin
      state_d = state_q;
      nch_d   = nch_q;
      ch_d    = ch_q;
      oy_d    = oy_q;
      ox_d    = ox_q;
      ky_d    = ky_q;
      kx_d    = kx_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (n_ch != '0) begin
                  nch_d   = n_ch;
                  ch_d    = '0;
                  oy_d    = '0;
                  ox_d    = '0;
                  ky_d    = '0;
                  kx_d    = '0;
                  state_d = RUN;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            if (kx_q == KX_W'(NKX - 1)) begin
               kx_d = '0;
               if (ky_q == KY_W'(NKY - 1)) begin
                  ky_d = '0;
                  if (ox_q == OX_W'(TOX - 1)) begin
                     ox_d = '0;
                     if (oy_q == OY_W'(TOY - 1)) begin
                        oy_d = '0;
                        ch_d = ch_q + CH_W'(1);
                     end else begin
                        oy_d = oy_q + OY_W'(1);
                     end
                  end else begin
                     ox_d = ox_q + OX_W'(1);
                  end
               end else begin
                  ky_d = ky_q + KY_W'(1);
               end
            end else begin
               kx_d = kx_q + KX_W'(1);
            end
            if (lastTap) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!rdV_q && !prodV_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state and loop counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         nch_q   <= '0;
         ch_q    <= '0;
         oy_q    <= '0;
         ox_q    <= '0;
         ky_q    <= '0;
         kx_q    <= '0;
      end else begin
         state_q <= state_d;
         nch_q   <= nch_d;
         ch_q    <= ch_d;
         oy_q    <= oy_d;
         ox_q    <= ox_d;
         ky_q    <= ky_d;
         kx_q    <= kx_d;
      end
   end

   // Accumulate and convert. The first tap of a pixel loads the product
   // rather than adding, so consecutive pixels need no clearing bubble.
   // Rounding is half-up in two's complement, i.e. floor(x + 0.5).
   always_comb begin
      prodExt = ACC_W'(prod_q);
      accSum  = prodFirst_q ? prodExt : (acc_q + prodExt);
      rounded = accSum + RND;
      shifted = rounded >>> FRAC;
      if (shifted > SAT_MAX) begin
         satPix = SAT_MAX[PX_W-1:0];
      end else if (shifted < SAT_MIN) begin
         satPix = SAT_MIN[PX_W-1:0];
      end else begin
         satPix = shifted[PX_W-1:0];
      end
      outPix = satPix;
`ifdef IRB_DW_RELU6_EN
      if (satPix[PX_W-1]) begin
         outPix = '0;
      end else if (satPix > RELU_MAX) begin
         outPix = RELU_MAX;
      end
`endif
   end

   // Pipeline registers: tags follow the data through read, multiply and
   // accumulate so the write address arrives with its result. Reset drops
   // everything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdV_q       <= 1'b0;
         rdFirst_q   <= 1'b0;
         rdLast_q    <= 1'b0;
         rdOaddr_q   <= '0;
         prodV_q     <= 1'b0;
         prodFirst_q <= 1'b0;
         prodLast_q  <= 1'b0;
         prodOaddr_q <= '0;
         prod_q      <= '0;
         acc_q       <= '0;
         fmoWr_q     <= 1'b0;
         fmoAddr_q   <= '0;
         fmoData_q   <= '0;
      end else begin
         rdV_q       <= running;
         rdFirst_q   <= firstOfPix;
         rdLast_q    <= lastOfPix;
         rdOaddr_q   <= issueOaddr;
         prodV_q     <= rdV_q;
         prodFirst_q <= rdFirst_q;
         prodLast_q  <= rdLast_q;
         prodOaddr_q <= rdOaddr_q;
         prod_q      <= PROD_W'($signed(fmint_data)) * PROD_W'($signed(kdw_data));
         if (prodV_q) begin
            acc_q <= accSum;
         end
         fmoWr_q   <= prodV_q && prodLast_q;
         fmoAddr_q <= (prodV_q && prodLast_q) ? prodOaddr_q : '0;
         fmoData_q <= (prodV_q && prodLast_q) ? outPix : '0;
      end
   end

   assign fmo_wr_en = fmoWr_q;
   assign fmo_addr  = fmoAddr_q;
   assign fmo_data  = fmoData_q;

endmodule

// File: tb/tb_irb_dw_engine.sv
// tb_irb_dw_engine
// Self-checking bench for irb_dw_engine. Memory models answer reads one
// cycle later; a reference model computes every expected output pixel into
// a scoreboard queue when a tile is started, and writes are popped and
// compared as the DUT produces them. Tile cycle numbers count from the
// edge that accepts start (edge 0, first read in cycle 1).

module tb_irb_dw_engine;

   localparam int FM_N = 81 * 32;
   localparam int KW_N = 9 * 32;

   logic        clk;
   logic        rst;
   logic        start;
   logic [5:0]  n_ch;
   logic        busy;
   logic        done;
   logic        fmint_rd_en;
   logic [11:0] fmint_addr;
   logic [15:0] fmint_data;
   logic        kdw_rd_en;
   logic [8:0]  kdw_addr;
   logic [15:0] kdw_data;
   logic        fmo_wr_en;
   logic [10:0] fmo_addr;
   logic [15:0] fmo_data;

   logic [15:0] fm [0:FM_N-1];
   logic [15:0] kw [0:KW_N-1];

   logic [10:0] expAddrQ [$];
   logic [15:0] expDataQ [$];

   int checks = 0;
   int errors = 0;

   irb_dw_engine dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .n_ch        (n_ch),
      .busy        (busy),
      .done        (done),
      .fmint_rd_en (fmint_rd_en),
      .fmint_addr  (fmint_addr),
      .fmint_data  (fmint_data),
      .kdw_rd_en   (kdw_rd_en),
      .kdw_addr    (kdw_addr),
      .kdw_data    (kdw_data),
      .fmo_wr_en   (fmo_wr_en),
      .fmo_addr    (fmo_addr),
      .fmo_data    (fmo_data)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous RAM models with one cycle of read latency
   always @(posedge clk) begin
      if (fmint_rd_en) fmint_data <= fm[fmint_addr];
      if (kdw_rd_en)   kdw_data   <= kw[kdw_addr];
   end

   // Hard stop in case a wait somewhere never resolves
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference output pixel: full-precision sum, round half up, saturate
   function automatic logic [15:0] modelPix(input int ch, input int oy, input int ox);
      longint s;
      s = 0;
      for (int ky = 0; ky < 3; ky++) begin
         for (int kx = 0; kx < 3; kx++) begin
            s += longint'($signed(fm[ch*81 + (oy+ky)*9 + ox + kx]))
               * longint'($signed(kw[ch*9 + ky*3 + kx]));
         end
      end
      s = (s + 128) >>> 8;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`ifdef IRB_DW_RELU6_EN
      if (s < 0)    s = 0;
      if (s > 1536) s = 1536;
`endif
      return s[15:0];
   endfunction

   // Starts a tile, fills the scoreboard and checks every write plus the
   // tile-level timing. pulseAt re-pulses start mid-run; rstAt aborts.
   task automatic applyStimulus(input int nch, input int expDone, input int pulseAt,
                                input int rstAt, input string name);
      int  cyc;
      int  writes;
      int  firstWr;
      int  doneCyc;
      bit  seenDone;
      logic [10:0] ea;
      logic [15:0] ed;
      expAddrQ.delete();
      expDataQ.delete();
      for (int c = 0; c < nch; c++)
         for (int oy = 0; oy < 7; oy++)
            for (int ox = 0; ox < 7; ox++) begin
               expAddrQ.push_back(11'(c*49 + oy*7 + ox));
               expDataQ.push_back(modelPix(c, oy, ox));
            end
      writes   = 0;
      firstWr  = -1;
      doneCyc  = -1;
      seenDone = 1'b0;
      @(negedge clk);
      start = 1'b1;
      n_ch  = 6'(nch);
      @(posedge clk);
      cyc = 0;
      while (cyc < expDone + 30 && !seenDone) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (cyc == pulseAt) begin
            start = 1'b1;
            n_ch  = 6'd5;
         end else if (pulseAt > 0 && cyc == pulseAt + 1) begin
            start = 1'b0;
         end
         if (fmo_wr_en) begin
            writes++;
            if (firstWr < 0) firstWr = cyc;
            checks++;
            if (expAddrQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL %s unexpected write: got addr %0d data %h, required none", name, fmo_addr, fmo_data);
            end else begin
               ea = expAddrQ.pop_front();
               ed = expDataQ.pop_front();
               if (fmo_addr !== ea || fmo_data !== ed) begin
                  errors++;
                  $display("[TB] FAIL %s write: got addr %0d data %h, required addr %0d data %h",
                           name, fmo_addr, fmo_data, ea, ed);
               end
            end
         end
         if (nch == 0 && (fmint_rd_en || kdw_rd_en)) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s read with n_ch=0 at cycle %0d", name, cyc);
         end
         if (done) begin
            seenDone = 1'b1;
            doneCyc  = cyc;
         end
         if (rstAt > 0 && cyc == rstAt) begin
            rst = 1'b1;
            @(negedge clk);
            checks++;
            if ({busy, done, fmint_rd_en, kdw_rd_en, fmo_wr_en, fmint_addr, kdw_addr, fmo_addr, fmo_data} !== '0) begin
               errors++;
               $display("[TB] FAIL %s outputs after reset: got busy %b done %b wr %b, required all zero",
                        name, busy, done, fmo_wr_en);
            end
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               checks++;
               if (fmo_wr_en || done || busy) begin
                  errors++;
                  $display("[TB] FAIL %s activity after abort: got wr %b done %b busy %b, required 0 0 0",
                           name, fmo_wr_en, done, busy);
               end
            end
            expAddrQ.delete();
            expDataQ.delete();
            return;
         end
      end
      checks++;
      if (doneCyc != expDone) begin
         errors++;
         $display("[TB] FAIL %s done cycle: got %0d, required %0d", name, doneCyc, expDone);
      end
      checks++;
      if (writes != nch * 49) begin
         errors++;
         $display("[TB] FAIL %s write count: got %0d, required %0d", name, writes, nch * 49);
      end
      if (nch > 0) begin
         checks++;
         if (firstWr != 12) begin
            errors++;
            $display("[TB] FAIL %s first write cycle: got %0d, required 12", name, firstWr);
         end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s idle after done: got busy %b done %b, required 0 0", name, busy, done);
      end
   endtask

   task automatic fillConst(input logic [15:0] px, input logic [15:0] wt);
      for (int i = 0; i < FM_N; i++) fm[i] = px;
      for (int i = 0; i < KW_N; i++) kw[i] = wt;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      n_ch  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, fmint_rd_en, kdw_rd_en, fmo_wr_en, fmint_addr, kdw_addr, fmo_addr, fmo_data} !== '0) begin
         errors++;
         $display("[TB] FAIL reset outputs: got busy %b done %b rd %b wr %b data %h, required all zero",
                  busy, done, fmint_rd_en, fmo_wr_en, fmo_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_ones();
      fillConst(16'd256, 16'd256);
      applyStimulus(1, 445, -1, -1, "ones");
   endtask

   task automatic test_identity();
      int v;
      for (int c = 0; c < 32; c++)
         for (int y = 0; y < 9; y++)
            for (int x = 0; x < 9; x++) begin
               v = (y*9 + x + 1000*c) * 256;
               fm[c*81 + y*9 + x] = (v > 32767) ? 16'h7FFF : 16'(v);
            end
      for (int i = 0; i < KW_N; i++) kw[i] = ((i % 9) == 4) ? 16'd256 : 16'd0;
      applyStimulus(2, 2*441 + 4, -1, -1, "identity");
   endtask

   task automatic test_saturation();
      fillConst(16'h7FFF, 16'h7FFF);
      applyStimulus(1, 445, -1, -1, "sat_pos");
      fillConst(16'd256, 16'hFF00);
      applyStimulus(1, 445, -1, -1, "sat_sign");
   endtask

   task automatic test_rounding();
      for (int i = 0; i < KW_N; i++) kw[i] = ((i % 9) == 4) ? 16'd1 : 16'd0;
      for (int i = 0; i < FM_N; i++) fm[i] = 16'd128;
      applyStimulus(1, 445, -1, -1, "round_up");
      for (int i = 0; i < FM_N; i++) fm[i] = 16'hFF7F;
      applyStimulus(1, 445, -1, -1, "round_neg");
   endtask

   task automatic test_control();
      for (int i = 0; i < FM_N; i++) fm[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
      for (int i = 0; i < KW_N; i++) kw[i] = 16'($urandom_range(0, 1023)) - 16'd512;
      applyStimulus(32, 14116, 100, -1, "full_tile");
      applyStimulus(0, 1, -1, -1, "zero_ch");
   endtask

   task automatic test_reset_midrun();
      fillConst(16'd256, 16'd256);
      applyStimulus(1, 445, -1, 200, "abort");
      for (int i = 0; i < FM_N; i++) fm[i] = 16'($urandom_range(0, 4095)) - 16'd2048;
      for (int i = 0; i < KW_N; i++) kw[i] = 16'($urandom_range(0, 511)) - 16'd256;
      applyStimulus(1, 445, -1, -1, "after_abort");
   endtask

   task automatic test_back_to_back();
      applyStimulus(3, 3*441 + 4, -1, -1, "b2b_a");
      applyStimulus(1, 445, -1, -1, "b2b_b");
   endtask

   initial begin
      fmint_data = '0;
      kdw_data   = '0;
      test_reset();
      test_ones();
      test_identity();
      test_saturation();
      test_rounding();
      test_control();
      test_reset_midrun();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
